// File: rtl/demux32_buffered_if.sv
// Bundle between one result producer and the two consumer channels of demux32_buffered.
// Latency: none (wires only).
// Backpressure: valid/ready on the input side and on each output channel.
//
// Ports / signals:
//   in_valid, in_ready, sel, in_data       producer side (sel: 0 = A, 1 = B)
//   outA_valid/ready/data, levelA          channel A head word and occupancy
//   outB_valid/ready/data, levelB          channel B head word and occupancy
// Modports: master = producer/consumer side, slave = the demux itself.
interface demux32_buffered_if #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    logic                     in_valid;
    logic                     in_ready;
    logic                     sel;
    logic [WIDTH-1:0]         in_data;

    logic                     outA_valid;
    logic                     outA_ready;
    logic [WIDTH-1:0]         outA_data;
    logic [$clog2(DEPTH):0]   levelA;

    logic                     outB_valid;
    logic                     outB_ready;
    logic [WIDTH-1:0]         outB_data;
    logic [$clog2(DEPTH):0]   levelB;

    modport master (
        output in_valid, sel, in_data, outA_ready, outB_ready,
        input  in_ready, outA_valid, outA_data, levelA,
               outB_valid, outB_data, levelB
    );

    modport slave (
        input  in_valid, sel, in_data, outA_ready, outB_ready,
        output in_ready, outA_valid, outA_data, levelA,
               outB_valid, outB_data, levelB
    );
endinterface

// File: rtl/demux32_buffered.sv
// Steers each producer word to channel A or B (by sel), each channel buffered by its own FIFO.
// Latency: a word pushed at edge N is visible at the channel head in cycle N+1 (fall-through from registers).
// Backpressure: in_ready drops when the selected channel is full; a stalled channel never blocks the other.
//
// Ports:
//   clk      rising-edge clock
//   rst      synchronous reset, active-high (pointers/levels cleared, storage kept)
//   bus      demux32_buffered_if.slave (producer handshake, two consumer channels, levels)

// One channel: circular buffer with head/tail pointers and an explicit level
// so that full (level == DEPTH) and empty (level == 0) are unambiguous.
module demux32_buffered_chan #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    output logic                   full,
    output logic                   valid,
    input  logic                   ready,
    output logic [WIDTH-1:0]       data,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic             pop;

    assign full  = (level == FULL_LVL);
    assign valid = (level != '0);
    assign pop   = valid && ready;
    // Empty channel presents zero rather than stale storage.
    assign data  = valid ? mem[head] : '0;

    // DEPTH is a power of two, so natural pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            level <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (!push && pop)
                level <= level - 1'b1;
        end
    end

    // Storage is deliberately not reset; only writes are suppressed during rst.
    always_ff @(posedge clk) begin
        if (push && !rst)
            mem[tail] <= wr_data;
    end
endmodule

module demux32_buffered #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    demux32_buffered_if.slave  bus
);
    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;

    // Ready looks only at the selected channel's own fill level; a pop in
    // the same cycle does not open a slot for a push (no pass-through).
    assign bus.in_ready = bus.sel ? !full_b : !full_a;
    assign push_a       = bus.in_valid && bus.in_ready && !bus.sel;
    assign push_b       = bus.in_valid && bus.in_ready &&  bus.sel;

    demux32_buffered_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_a (
        .clk     (clk),
        .rst     (rst),
        .push    (push_a),
        .wr_data (bus.in_data),
        .full    (full_a),
        .valid   (bus.outA_valid),
        .ready   (bus.outA_ready),
        .data    (bus.outA_data),
        .level   (bus.levelA)
    );

    demux32_buffered_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan_b (
        .clk     (clk),
        .rst     (rst),
        .push    (push_b),
        .wr_data (bus.in_data),
        .full    (full_b),
        .valid   (bus.outB_valid),
        .ready   (bus.outB_ready),
        .data    (bus.outB_data),
        .level   (bus.levelB)
    );
endmodule

// File: tb/tb_demux32_buffered.sv
// Self-checking bench for demux32_buffered: queue-based channel model plus directed and random traffic.
// Latency: model applies pushes/pops at each rising edge; outputs compared on the falling edge.
// Backpressure: producer holds data/sel until accepted; consumer readies are directed or random.
module tb_demux32_buffered;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux32_buffered_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    demux32_buffered #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] popped_a[$];
    logic [31:0] popped_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: each channel is a bounded queue of capacity DEPTH.
    always @(posedge clk) begin : model
        bit acc, pa, pb;
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            acc = bus.in_valid && (bus.sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
            pa  = (qa.size() != 0) && bus.outA_ready;
            pb  = (qb.size() != 0) && bus.outB_ready;
            if (pa) popped_a.push_back(qa.pop_front());
            if (pb) popped_b.push_back(qb.pop_front());
            if (acc) begin
                if (bus.sel) qb.push_back(bus.in_data);
                else         qa.push_back(bus.in_data);
            end
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        logic [31:0] ea, eb;
        if (chk_en) begin
            ea = (qa.size() != 0) ? qa[0] : 32'h0;
            eb = (qb.size() != 0) ? qb[0] : 32'h0;
            chk("levelA",     32'(bus.levelA),     32'(qa.size()));
            chk("levelB",     32'(bus.levelB),     32'(qb.size()));
            chk("outA_valid", 32'(bus.outA_valid), 32'(qa.size() != 0));
            chk("outB_valid", 32'(bus.outB_valid), 32'(qb.size() != 0));
            chk("outA_data",  bus.outA_data,       ea);
            chk("outB_data",  bus.outB_data,       eb);
            chk("in_ready",   32'(bus.in_ready),
                32'(bus.sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH)));
            chk("level_bound", 32'(bus.levelA <= DEPTH && bus.levelB <= DEPTH), 32'd1);
        end
    end

    initial begin : timeout
        #200000;
        $display("FAIL timeout: simulation did not complete, got running, expected finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n0;
        int budget;
        bit tog;
        bit acc;

        // 1. Reset for two cycles with every input active.
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.sel        = 1'b0;
        bus.in_data    = $urandom;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        cyc();
        chk_en      = 1'b1;
        bus.sel     = 1'b1;
        bus.in_data = $urandom;
        cyc();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.sel      = 1'b0;
        #1;
        chk("t1_levelA",   32'(bus.levelA),     32'd0);
        chk("t1_levelB",   32'(bus.levelB),     32'd0);
        chk("t1_validA",   32'(bus.outA_valid), 32'd0);
        chk("t1_validB",   32'(bus.outB_valid), 32'd0);
        chk("t1_dataA",    bus.outA_data,       32'h0);
        chk("t1_dataB",    bus.outB_data,       32'h0);
        chk("t1_rdy_sel0", 32'(bus.in_ready),   32'd1);
        bus.sel = 1'b1;
        #1;
        chk("t1_rdy_sel1", 32'(bus.in_ready),   32'd1);

        // 2. One word to each channel, consumers always ready.
        bus.in_valid = 1'b1;
        bus.sel      = 1'b0;
        bus.in_data  = 32'h1111_1111;
        cyc();
        chk("t2_validA", 32'(bus.outA_valid), 32'd1);
        chk("t2_dataA",  bus.outA_data,       32'h1111_1111);
        bus.sel     = 1'b1;
        bus.in_data = 32'h2222_2222;
        cyc();
        chk("t2_validA_gone", 32'(bus.outA_valid), 32'd0);
        chk("t2_validB",      32'(bus.outB_valid), 32'd1);
        chk("t2_dataB",       bus.outB_data,       32'h2222_2222);
        bus.in_valid = 1'b0;
        cyc();
        chk("t2_levelA", 32'(bus.levelA), 32'd0);
        chk("t2_levelB", 32'(bus.levelB), 32'd0);

        // 3. Fill A while its consumer stalls; B still accepts.
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.sel        = 1'b0;
        bus.in_data    = 32'hA0;
        cyc();
        bus.in_data = 32'hA1;
        cyc();
        bus.in_valid = 1'b0;
        #1;
        chk("t3_levelA",   32'(bus.levelA),   32'd2);
        chk("t3_rdy_sel0", 32'(bus.in_ready), 32'd0);
        bus.sel = 1'b1;
        #1;
        chk("t3_rdy_sel1", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hB0;
        cyc();
        bus.in_valid = 1'b0;
        chk("t3_levelB", 32'(bus.levelB), 32'd1);

        // 4. Full A: pop and attempted push in the same cycle.
        bus.sel        = 1'b0;
        bus.in_valid   = 1'b1;
        bus.in_data    = 32'hA2;
        bus.outA_ready = 1'b1;
        #1;
        chk("t4_rdy_full", 32'(bus.in_ready), 32'd0);
        n0 = popped_a.size();
        cyc();
        chk("t4_levelA_pop", 32'(bus.levelA), 32'd1);
        bus.outA_ready = 1'b0;
        cyc();
        chk("t4_levelA_push", 32'(bus.levelA), 32'd2);
        bus.in_valid   = 1'b0;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        repeat (3) cyc();
        chk("t4_levelA_drained", 32'(bus.levelA), 32'd0);
        chk("t4_pop_count", 32'(popped_a.size() - n0), 32'd3);
        if (popped_a.size() >= n0 + 3) begin
            chk("t4_pop0", popped_a[n0],     32'hA0);
            chk("t4_pop1", popped_a[n0 + 1], 32'hA1);
            chk("t4_pop2", popped_a[n0 + 2], 32'hA2);
        end

        // 5. Ten-word stream into A with a toggling consumer.
        n0  = popped_a.size();
        tog = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.sel      = 1'b0;
            bus.in_data  = 32'(i);
            budget       = 0;
            acc          = 1'b0;
            while (!acc && budget < 20) begin
                bus.outA_ready = tog;
                tog            = !tog;
                #1;
                acc = bus.in_ready;
                cyc();
                budget++;
            end
            if (!acc) chk("t5_accept_timeout", 32'd0, 32'd1);
        end
        bus.in_valid   = 1'b0;
        bus.outA_ready = 1'b1;
        repeat (4) cyc();
        chk("t5_pop_count", 32'(popped_a.size() - n0), 32'd10);
        if (popped_a.size() >= n0 + 10) begin
            for (int i = 0; i < 10; i++)
                chk($sformatf("t5_order%0d", i), popped_a[n0 + i], 32'(i));
        end

        // Random traffic; producer holds its word until accepted.
        acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.sel      = $urandom_range(0, 1);
                bus.in_data  = $urandom;
            end
            bus.outA_ready = ($urandom_range(0, 2) != 0);
            bus.outB_ready = ($urandom_range(0, 3) == 0);
            #1;
            acc = bus.in_valid && bus.in_ready;
            cyc();
        end

        // 6. Reset mid-stream with levelA=2, levelB=1 and traffic active.
        bus.in_valid   = 1'b0;
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        repeat (3) cyc();
        bus.outA_ready = 1'b0;
        bus.outB_ready = 1'b0;
        bus.in_valid   = 1'b1;
        bus.sel        = 1'b0;
        bus.in_data    = 32'hC0;
        cyc();
        bus.in_data = 32'hC1;
        cyc();
        bus.sel     = 1'b1;
        bus.in_data = 32'hC2;
        cyc();
        chk("t6_levelA_pre", 32'(bus.levelA), 32'd2);
        chk("t6_levelB_pre", 32'(bus.levelB), 32'd1);
        bus.outA_ready = 1'b1;
        bus.outB_ready = 1'b1;
        bus.in_data    = 32'hC3;
        rst            = 1'b1;
        cyc();
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        chk("t6_levelA", 32'(bus.levelA),     32'd0);
        chk("t6_levelB", 32'(bus.levelB),     32'd0);
        chk("t6_validA", 32'(bus.outA_valid), 32'd0);
        chk("t6_validB", 32'(bus.outB_valid), 32'd0);
        chk("t6_dataA",  bus.outA_data,       32'h0);
        chk("t6_dataB",  bus.outB_data,       32'h0);
        n0     = popped_a.size();
        budget = popped_b.size();
        repeat (3) cyc();
        chk("t6_no_emitA", 32'(popped_a.size() - n0),     32'd0);
        chk("t6_no_emitB", 32'(popped_b.size() - budget), 32'd0);
        chk("t6_validA_after", 32'(bus.outA_valid), 32'd0);
        chk("t6_validB_after", 32'(bus.outB_valid), 32'd0);

        @(negedge clk);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
